// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder
// Takes the bit-reversed bin stream of the 16-point SDF FFT and re-emits it in
// natural order. Each frame is scattered into one of two register-file banks at
// its bit-reversed address, then the full bank is swept linearly while the
// other bank fills. One sample per clock in and out, no back-pressure.
module fft_bitrev_reorder #(
  parameter int WIDTH    = 16,
  parameter int N_POINTS = 16,
  parameter int LOG2_N   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [WIDTH-1:0]  FFT_Re,
  input  logic signed [WIDTH-1:0]  FFT_Im,
  input  logic                     Data_Valid,
  output logic signed [WIDTH-1:0]  Out_Re,
  output logic signed [WIDTH-1:0]  Out_Im,
  output logic                     Out_Valid,
  output logic [LOG2_N-1:0]        Out_Bin,
  output logic                     Frame_Start,
  output logic                     Frame_End
);

  localparam int DEPTH = 2 * N_POINTS;
  localparam logic [LOG2_N-1:0] LAST = LOG2_N'(N_POINTS - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  // Mirror the index bits: input slot k holds natural bin bitrev(k).
  function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] a);
    logic [LOG2_N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2_N; i++) r[i] = a[LOG2_N-1-i];
    return r;
  endfunction

  // Bank b occupies addresses {b, idx}.
  logic [2*WIDTH-1:0] mem [DEPTH];

  logic              wr_bank;
  logic [LOG2_N-1:0] wr_cnt;
  logic              wr_last;
  logic [1:0]        full;
  logic [1:0]        full_set;
  logic [1:0]        full_clr;

  state_t            state, state_nxt;
  logic              rd_bank, rd_bank_nxt;
  logic [LOG2_N-1:0] rd_cnt, rd_cnt_nxt;
  logic              emit;
  logic              rd_done;
  logic [2*WIDTH-1:0] rd_word;

  assign wr_last = Data_Valid && (wr_cnt == LAST);
  assign rd_word = mem[{rd_bank, rd_cnt}];

  // ---- write stage: scatter incoming samples into the write bank ----

  // Write pointer and bank select advance once per accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (Data_Valid) begin
      wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
      if (wr_last) wr_bank <= ~wr_bank;
    end
  end

  // Sample storage; contents survive reset, only the bookkeeping is cleared.
  always_ff @(posedge clk) begin
    if (Data_Valid && !rst) mem[{wr_bank, bitrev(wr_cnt)}] <= {FFT_Re, FFT_Im};
  end

  // Full-flag set by the writer and clear by the reader are independent per bank.
  always_comb begin
    full_set = '0;
    full_clr = '0;
    if (wr_last) full_set[wr_bank] = 1'b1;
    if (rd_done) full_clr[rd_bank] = 1'b1;
  end

  // Bank occupancy flags.
  always_ff @(posedge clk) begin
    if (rst) full <= '0;
    else     full <= (full & ~full_clr) | full_set;
  end

  // ---- read stage: sweep the full bank in natural order ----

  // Read FSM state, pointer and bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_cnt  <= rd_cnt_nxt;
      rd_bank <= rd_bank_nxt;
    end
  end

  // IDLE starts emitting bin 0 on the very edge it sees a full bank, so a
  // bank that fills during the last bin of the previous frame leaves no bubble.
  always_comb begin
    state_nxt   = state;
    rd_cnt_nxt  = rd_cnt;
    rd_bank_nxt = rd_bank;
    emit        = 1'b0;
    rd_done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (full[rd_bank]) begin
          emit      = 1'b1;
          state_nxt = S_STREAM;
        end
      end
      S_STREAM: emit = 1'b1;
      default:  state_nxt = S_IDLE;
    endcase
    if (emit) begin
      rd_cnt_nxt = rd_cnt + 1'b1;
      if (rd_cnt == LAST) begin
        rd_done     = 1'b1;
        rd_cnt_nxt  = '0;
        rd_bank_nxt = ~rd_bank;
        state_nxt   = full[!rd_bank] ? S_STREAM : S_IDLE;
      end
    end
  end

  // ---- output stage: registered data, index and frame markers ----

  // Data outputs hold their last value between frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      Out_Re      <= '0;
      Out_Im      <= '0;
      Out_Bin     <= '0;
      Out_Valid   <= 1'b0;
      Frame_Start <= 1'b0;
      Frame_End   <= 1'b0;
    end else begin
      Out_Valid   <= emit;
      Frame_Start <= emit && (rd_cnt == '0);
      Frame_End   <= emit && (rd_cnt == LAST);
      if (emit) begin
        Out_Re  <= rd_word[2*WIDTH-1:WIDTH];
        Out_Im  <= rd_word[WIDTH-1:0];
        Out_Bin <= rd_cnt;
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: scripted/randomized input plans, a frame-level
// scheduling model of the expected natural-order output, per-scenario checks.
module tb_fft_bitrev_reorder;
  localparam int W = 16;
  localparam int N = 16;
  localparam int L = 4;

  logic clk_tb = 1'b0;
  logic rst;
  logic signed [W-1:0] FFT_Re, FFT_Im;
  logic Data_Valid;
  logic signed [W-1:0] Out_Re, Out_Im;
  logic Out_Valid;
  logic [L-1:0] Out_Bin;
  logic Frame_Start, Frame_End;

  always #5 clk_tb = ~clk_tb;

  fft_bitrev_reorder #(.WIDTH(W), .N_POINTS(N), .LOG2_N(L)) dut (
    .clk(clk_tb), .rst(rst), .FFT_Re(FFT_Re), .FFT_Im(FFT_Im),
    .Data_Valid(Data_Valid), .Out_Re(Out_Re), .Out_Im(Out_Im),
    .Out_Valid(Out_Valid), .Out_Bin(Out_Bin),
    .Frame_Start(Frame_Start), .Frame_End(Frame_End)
  );

  int total = 0;
  int bad = 0;

  // Input plan, one entry per clock.
  logic d_v[$];
  logic signed [W-1:0] d_re[$], d_im[$];
  logic d_rst[$];

  // Captured outputs, index c = outputs after the edge that took plan entry c.
  logic c_v[$];
  logic signed [W-1:0] c_re[$], c_im[$];
  logic [L-1:0] c_bin[$];
  logic c_fs[$], c_fe[$];

  // Expected outputs per capture index.
  logic e_v[];
  logic signed [W-1:0] e_re[], e_im[];
  logic [L-1:0] e_bin[];

  int rtab[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  function automatic int brev(input int k);
    int r = 0;
    for (int b = 0; b < L; b++) if (k[b]) r |= (1 << (L - 1 - b));
    return r;
  endfunction

  task automatic plan(input logic v, input logic signed [W-1:0] re,
                      input logic signed [W-1:0] im, input logic r);
    d_v.push_back(v); d_re.push_back(re); d_im.push_back(im); d_rst.push_back(r);
  endtask

  // Frame model: the k-th accepted sample of a frame is natural bin brev(k).
  // A completed frame streams from max(ready+1, end of previous stream);
  // a reset wipes every output from its edge on and any partial frame.
  task automatic build_model(input int n);
    logic signed [W-1:0] fr_re[N], fr_im[N];
    int cnt = 0;
    int sfree = 0;
    int start, c;
    e_v = new[n]; e_re = new[n]; e_im = new[n]; e_bin = new[n];
    for (int i = 0; i < n; i++) begin
      e_v[i] = 1'b0; e_re[i] = '0; e_im[i] = '0; e_bin[i] = '0;
    end
    for (int i = 0; i < d_v.size(); i++) begin
      if (d_rst[i]) begin
        for (int j = i; j < n; j++) e_v[j] = 1'b0;
        cnt = 0;
        sfree = 0;
      end else if (d_v[i]) begin
        fr_re[cnt] = d_re[i];
        fr_im[cnt] = d_im[i];
        cnt++;
        if (cnt == N) begin
          start = (i + 1 > sfree) ? i + 1 : sfree;
          for (int k = 0; k < N; k++) begin
            c = start + brev(k);
            if (c < n) begin
              e_v[c] = 1'b1; e_re[c] = fr_re[k]; e_im[c] = fr_im[k];
              e_bin[c] = L'(brev(k));
            end
          end
          sfree = start + N;
          cnt = 0;
        end
      end
    end
  endtask

  task automatic drive_all();
    for (int i = 0; i < d_v.size(); i++) begin
      Data_Valid = d_v[i]; FFT_Re = d_re[i]; FFT_Im = d_im[i]; rst = d_rst[i];
      @(posedge clk_tb); #1;
    end
    Data_Valid = 1'b0; rst = 1'b0;
  endtask

  task automatic capture(input int n);
    c_v.delete(); c_re.delete(); c_im.delete(); c_bin.delete(); c_fs.delete(); c_fe.delete();
    @(posedge clk_tb);
    repeat (n) begin
      @(negedge clk_tb);
      c_v.push_back(Out_Valid); c_re.push_back(Out_Re); c_im.push_back(Out_Im);
      c_bin.push_back(Out_Bin); c_fs.push_back(Frame_Start); c_fe.push_back(Frame_End);
    end
  endtask

  task automatic run(input int n);
    @(posedge clk_tb); #1;
    build_model(n);
    fork
      drive_all();
      capture(n);
    join
    d_v.delete(); d_re.delete(); d_im.delete(); d_rst.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; Data_Valid = 1'b0; FFT_Re = '0; FFT_Im = '0;
    repeat (3) @(posedge clk_tb);
    #1;
    total++;
    if ({Out_Re, Out_Im, Out_Bin, Out_Valid, Frame_Start, Frame_End} !== '0) begin
      bad++;
      $display("FAIL reset_values got %h required 0",
               {Out_Re, Out_Im, Out_Bin, Out_Valid, Frame_Start, Frame_End});
    end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_tb);
      total++;
      if ({Out_Valid, Frame_Start, Frame_End} !== 3'b000) begin
        bad++;
        $display("FAIL reset_idle cycle %0d got v/fs/fe=%b required 000", i,
                 {Out_Valid, Frame_Start, Frame_End});
      end
    end
  endtask

  task automatic test_index_pattern();
    for (int k = 0; k < N; k++) plan(1'b1, W'(k), W'(-k), 1'b0);
    run(40);
    for (int c = 0; c < 40; c++) begin
      total++;
      if (c_v[c] !== e_v[c]) begin
        bad++; $display("FAIL index_valid c=%0d got %b required %b", c, c_v[c], e_v[c]);
      end
      if (e_v[c]) begin
        total++;
        if ({c_re[c], c_im[c], c_bin[c], c_fs[c], c_fe[c]} !==
            {e_re[c], e_im[c], e_bin[c], e_bin[c] == 0, e_bin[c] == L'(N - 1)}) begin
          bad++;
          $display("FAIL index_data c=%0d got %h required %h", c,
                   {c_re[c], c_im[c], c_bin[c], c_fs[c], c_fe[c]},
                   {e_re[c], e_im[c], e_bin[c], e_bin[c] == 0, e_bin[c] == L'(N - 1)});
        end
      end
    end
    for (int j = 0; j < N; j++) begin
      total++;
      if (c_re[16 + j] !== W'(rtab[j]) || c_im[16 + j] !== W'(-rtab[j])) begin
        bad++;
        $display("FAIL index_table bin %0d got %0d/%0d required %0d/%0d", j,
                 c_re[16 + j], c_im[16 + j], rtab[j], -rtab[j]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nv = 0;
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < N; k++) plan(1'b1, W'(16 * f + k), W'($urandom), 1'b0);
    run(88);
    for (int c = 0; c < 88; c++) begin
      total++;
      if (c_v[c] !== e_v[c]) begin
        bad++; $display("FAIL b2b_valid c=%0d got %b required %b", c, c_v[c], e_v[c]);
      end
      if (c_v[c] === 1'b1) nv++;
      if (e_v[c]) begin
        total++;
        if ({c_re[c], c_im[c], c_bin[c], c_fs[c], c_fe[c]} !==
            {e_re[c], e_im[c], e_bin[c], e_bin[c] == 0, e_bin[c] == L'(N - 1)}) begin
          bad++;
          $display("FAIL b2b_data c=%0d got %h required %h", c,
                   {c_re[c], c_im[c], c_bin[c], c_fs[c], c_fe[c]},
                   {e_re[c], e_im[c], e_bin[c], e_bin[c] == 0, e_bin[c] == L'(N - 1)});
        end
      end
    end
    total++;
    if (nv != 64) begin
      bad++; $display("FAIL b2b_count got %0d required 64", nv);
    end
  endtask

  task automatic test_gapped();
    for (int k = 0; k < N; k++) begin
      plan(1'b1, W'(k), W'(-k), 1'b0);
      if (k < N - 1) plan(1'b0, W'($urandom), W'($urandom), 1'b0);
    end
    run(60);
    for (int c = 0; c < 60; c++) begin
      total++;
      if (c_v[c] !== e_v[c]) begin
        bad++; $display("FAIL gap_valid c=%0d got %b required %b", c, c_v[c], e_v[c]);
      end
      if (e_v[c]) begin
        total++;
        if ({c_re[c], c_im[c], c_bin[c], c_fs[c], c_fe[c]} !==
            {e_re[c], e_im[c], e_bin[c], e_bin[c] == 0, e_bin[c] == L'(N - 1)}) begin
          bad++;
          $display("FAIL gap_data c=%0d got %h required %h", c,
                   {c_re[c], c_im[c], c_bin[c], c_fs[c], c_fe[c]},
                   {e_re[c], e_im[c], e_bin[c], e_bin[c] == 0, e_bin[c] == L'(N - 1)});
        end
      end
    end
    for (int j = 0; j < N; j++) begin
      total++;
      if (c_v[31 + j] !== 1'b1 || c_re[31 + j] !== W'(rtab[j]) || c_im[31 + j] !== W'(-rtab[j])) begin
        bad++;
        $display("FAIL gap_table bin %0d got v=%b %0d/%0d required 1 %0d/%0d", j,
                 c_v[31 + j], c_re[31 + j], c_im[31 + j], rtab[j], -rtab[j]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int nv = 0;
    for (int k = 0; k < 9; k++) plan(1'b1, W'($urandom), W'($urandom), 1'b0);
    plan(1'b0, '0, '0, 1'b1);
    for (int k = 0; k < N; k++) plan(1'b1, W'($urandom), W'($urandom), 1'b0);
    run(50);
    for (int c = 0; c < 50; c++) begin
      total++;
      if (c_v[c] !== e_v[c]) begin
        bad++; $display("FAIL rstframe_valid c=%0d got %b required %b", c, c_v[c], e_v[c]);
      end
      if (c_v[c] === 1'b1) nv++;
      if (e_v[c]) begin
        total++;
        if ({c_re[c], c_im[c], c_bin[c], c_fs[c], c_fe[c]} !==
            {e_re[c], e_im[c], e_bin[c], e_bin[c] == 0, e_bin[c] == L'(N - 1)}) begin
          bad++;
          $display("FAIL rstframe_data c=%0d got %h required %h", c,
                   {c_re[c], c_im[c], c_bin[c], c_fs[c], c_fe[c]},
                   {e_re[c], e_im[c], e_bin[c], e_bin[c] == 0, e_bin[c] == L'(N - 1)});
        end
      end
    end
    total++;
    if (nv != 16) begin
      bad++; $display("FAIL rstframe_count got %0d required 16", nv);
    end
  endtask

  task automatic test_reset_mid_stream();
    for (int k = 0; k < 2 * N; k++) begin
      if (k == 22) plan(1'b0, '0, '0, 1'b1);
      else         plan(1'b1, W'($urandom), W'($urandom), 1'b0);
    end
    run(70);
    total++;
    if (c_v[21] !== 1'b1 || c_bin[21] !== 4'd5) begin
      bad++; $display("FAIL rststream_bin5 got v=%b bin=%0d required 1 5", c_v[21], c_bin[21]);
    end
    total++;
    if ({c_v[22], c_re[22], c_im[22], c_bin[22]} !== '0) begin
      bad++;
      $display("FAIL rststream_after got %h required 0", {c_v[22], c_re[22], c_im[22], c_bin[22]});
    end
    for (int c = 0; c < 70; c++) begin
      total++;
      if (c_v[c] !== e_v[c]) begin
        bad++; $display("FAIL rststream_valid c=%0d got %b required %b", c, c_v[c], e_v[c]);
      end
      if (e_v[c]) begin
        total++;
        if ({c_re[c], c_im[c], c_bin[c], c_fs[c], c_fe[c]} !==
            {e_re[c], e_im[c], e_bin[c], e_bin[c] == 0, e_bin[c] == L'(N - 1)}) begin
          bad++;
          $display("FAIL rststream_data c=%0d got %h required %h", c,
                   {c_re[c], c_im[c], c_bin[c], c_fs[c], c_fe[c]},
                   {e_re[c], e_im[c], e_bin[c], e_bin[c] == 0, e_bin[c] == L'(N - 1)});
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; Data_Valid = 1'b0; FFT_Re = '0; FFT_Im = '0;
    test_reset();
    test_index_pattern();
    test_back_to_back();
    test_gapped();
    test_reset_mid_frame();
    test_reset_mid_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Output reorder stage placed directly downstream of the 16-point radix-2² SDF FFT top. The FFT emits its bins in bit-reversed order, one complex sample per `Data_Valid` cycle. This block buffers each 16-sample frame in a ping-pong pair of register-file banks and streams the bins out in natural order (bin 0..15), tagged with the bin index and frame markers. There is no back-pressure: the block sustains one sample per clock in and out, continuously.

## Interface
- `WIDTH`, 16, bit width of the real and imaginary parts (signed, Q-format passed through untouched).
- `N_POINTS`, 16, FFT frame length; must equal 2^`LOG2_N`.
- `LOG2_N`, 4, index width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `FFT_Re`  in  WIDTH  real part from FFT (bit-reversed order).
- `FFT_Im`  in  WIDTH  imaginary part from FFT.
- `Data_Valid`  in  1  input sample qualifier; one sample accepted per high cycle.
- `Out_Re`  out  WIDTH  real part, natural order.
- `Out_Im`  out  WIDTH  imaginary part, natural order.
- `Out_Valid`  out  1  output qualifier.
- `Out_Bin`  out  LOG2_N  natural bin index of the current output.
- `Frame_Start`  out  1  high with bin 0.
- `Frame_End`  out  1  high with bin N_POINTS-1.

## Operation
- Storage: two banks (0/1) × N_POINTS entries × 2·WIDTH bits. Each bank has a `full` flag.
- Write side:
  - `wr_bank` starts at 0 and `wr_cnt` starts at 0.
  - On each edge with `Data_Valid`=1, write {`FFT_Re`,`FFT_Im`} to `bank[wr_bank][bitrev(wr_cnt)]`, then increment `wr_cnt`.
  - When `wr_cnt`=N_POINTS-1 is written: set `full[wr_bank]`, toggle `wr_bank`, and wrap `wr_cnt` to 0.
  - `Data_Valid` gaps inside a frame hold `wr_cnt`; the partial frame is kept.
- Read FSM:
  - IDLE: `rd_cnt`=0. If `full[rd_bank]`, go to STREAM on the same edge and emit bin 0.
  - STREAM: each edge, register `bank[rd_bank][rd_cnt]` onto the outputs, set `Out_Valid`=1 and `Out_Bin`=`rd_cnt`, then increment `rd_cnt`.
  - After emitting bin N_POINTS-1: clear `full[rd_bank]` and toggle `rd_bank`. If the other bank is already full, the next edge emits its bin 0 (back-to-back, no bubble). Otherwise return to IDLE.
- Simultaneous events: setting `full` on one bank and clearing it on the other in the same edge are both honoured. The write bank never equals a full bank being read, because the fill time (≥16 cycles) is at least the drain time (16 cycles). No overflow path exists.
- Reset:
  - Behaviour: at any point, including mid-frame or mid-stream, a reset discards partial and buffered frames. It clears `wr_cnt`, `rd_cnt`, `wr_bank`, `rd_bank`, both `full` flags and the FSM (to IDLE).
  - Reset values: `Out_Re`, `Out_Im`, `Out_Bin` = 0; `Out_Valid`, `Frame_Start`, `Frame_End` = 0.
  - Bank contents are not reset.
- Outside STREAM, `Out_Valid`, `Frame_Start` and `Frame_End` are 0, and the data outputs hold their last value.
- No arithmetic is applied to the data; values pass through bit-exact.

## Timing
- Frame-level latency: the last input sample of a frame is accepted at edge t. Bin 0 appears after edge t+1 and bin j after edge t+1+j.
- Sample-level latency: with continuous input starting at edge e0, bin j of frame f is valid after edge e0+16(f+1)+j.
- Continuous input gives continuous `Out_Valid` from edge e0+16 onward.
- Latency from first input to first output is 16 cycles; minimum latency from last input to bin 0 is 1 cycle.
- `Frame_Start`/`Frame_End` are single-cycle pulses aligned with `Out_Valid`.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- Reset values: assert `rst` for 3 cycles → all outputs are 0 and `Out_Valid` stays 0 for 40 cycles with `Data_Valid`=0.
- Index pattern: drive one frame with `FFT_Re`=k and `FFT_Im`=−k for k=0..15, continuous → `Out_Re` = 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 and `Out_Im` the negatives. `Frame_Start` at bin 0, `Frame_End` at bin 15, first output 1 cycle after the last input.
- Back-to-back: 4 continuous frames, with frame f data = 16f+k → 64 consecutive `Out_Valid` cycles, each frame correctly unscrambled, and `Out_Bin` wrapping 15→0 with no bubble.
- Gapped input: `Data_Valid` toggles 1,0,1,0 across one frame → identical output to the index-pattern test, starting 1 cycle after the 16th accepted sample.
- Reset mid-frame: apply `rst` after 9 input samples, then send a full fresh frame → only the fresh frame is output, with correct order.
- Reset mid-stream: apply `rst` during bin 5 → `Out_Valid`=0 on the next cycle, and no remaining bins or pending bank are emitted afterwards.
